// File: rtl/mux4_rr_sched.sv
// -----------------------------------------------------------------------------
// mux4_rr_sched
// Round-robin scheduler for a shared external 4:1 mux (inputs a,b,c,d; selects
// x,y). Grants one requester at a time for a bounded burst, then passes
// ownership to the next requester in circular order.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   req       in   4      requests, bit0=a bit1=b bit2=c bit3=d
//   grant     out  4      registered one-hot grant, zero when idle
//   x         out  1      mux select, owner index bit0 (held while idle)
//   y         out  1      mux select, owner index bit1 (held while idle)
//   busy      out  1      high while a grant is active
//   hold_cnt  out  CNT_W  cycles into the current grant (1..HOLD_MAX), 0 idle
// -----------------------------------------------------------------------------
module mux4_rr_sched #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic [3:0]       grant,
  output logic             x,
  output logic             y,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [1:0]       ptr_r;
  logic [1:0]       ptr_nx_s;
  logic [3:0]       grant_nx_s;
  logic             x_nx_s;
  logic             y_nx_s;
  logic [CNT_W-1:0] hold_nx_s;
  logic [1:0]       owner_s;
  logic [1:0]       win_s;
  logic             release_s;

  // First set request bit scanning circularly from the pointer.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // The selects always hold the owner index while a grant is active.
  assign owner_s   = {y, x};
  assign win_s     = pick_winner(req, ptr_r);
  assign release_s = !req[owner_s] || (hold_cnt == HOLD_MAX_C);

  // Next-state and next-output decode.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    grant_nx_s = grant;
    x_nx_s     = x;
    y_nx_s     = y;
    hold_nx_s  = hold_cnt;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          state_nx_s = BUSY;
          grant_nx_s = 4'b0001 << win_s;
          x_nx_s     = win_s[0];
          y_nx_s     = win_s[1];
          hold_nx_s  = CNT_ONE;
          ptr_nx_s   = win_s + 2'd1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (!release_s) begin
          hold_nx_s = hold_cnt + CNT_ONE;
        end else if (req != 4'b0000) begin
          // Owner is already demoted by the pointer, so it only wins if alone.
          state_nx_s = BUSY;
          grant_nx_s = 4'b0001 << win_s;
          x_nx_s     = win_s[0];
          y_nx_s     = win_s[1];
          hold_nx_s  = CNT_ONE;
          ptr_nx_s   = win_s + 2'd1;
        end else begin
          // Selects keep their value so the mux does not glitch back to a.
          state_nx_s = IDLE;
          grant_nx_s = 4'b0000;
          hold_nx_s  = CNT_ZERO;
        end
      end
      default: begin
        state_nx_s = IDLE;
        grant_nx_s = 4'b0000;
        hold_nx_s  = CNT_ZERO;
      end
    endcase
  end

  // State, pointer and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= 2'd0;
      grant    <= 4'b0000;
      x        <= 1'b0;
      y        <= 1'b0;
      busy     <= 1'b0;
      hold_cnt <= CNT_ZERO;
    end else begin
      state_r  <= state_nx_s;
      ptr_r    <= ptr_nx_s;
      grant    <= grant_nx_s;
      x        <= x_nx_s;
      y        <= y_nx_s;
      busy     <= (state_nx_s == BUSY);
      hold_cnt <= hold_nx_s;
    end
  end

endmodule

// File: tb/tb_mux4_rr_sched.sv
module tb_mux4_rr_sched;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       x;
  logic       y;
  logic       busy;
  logic [3:0] hold_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mux4_rr_sched #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 idle), cycles in burst, next-scan start, last selects.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  int m_x     = 0;
  int m_y     = 0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  // Spec-level update of the reference model at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1; m_cnt <= 0; m_ptr <= 0; m_x <= 0; m_y <= 0;
    end else if (m_owner >= 0 && req[m_owner & 3] && m_cnt < HOLD) begin
      m_cnt <= m_cnt + 1;
    end else if (req != 4'b0000) begin
      m_owner <= first_from(req, m_ptr);
      m_cnt   <= 1;
      m_ptr   <= (first_from(req, m_ptr) + 1) % 4;
      m_x     <= first_from(req, m_ptr) % 2;
      m_y     <= first_from(req, m_ptr) / 2;
    end else begin
      m_owner <= -1; m_cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_grant", {28'd0, grant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("m_x", {31'd0, x}, 32'(m_x));
      chk("m_y", {31'd0, y}, 32'(m_y));
      chk("m_busy", {31'd0, busy}, (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("m_hold", {28'd0, hold_cnt}, 32'(m_cnt));
    end
  end

  task automatic lit(input string tag, input logic [3:0] g, input logic ex, input logic ey,
                     input logic eb, input logic [3:0] h);
    chk({tag, "_grant"}, {28'd0, grant}, {28'd0, g});
    chk({tag, "_xy"}, {30'd0, x, y}, {30'd0, ex, ey});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, "_hold"}, {28'd0, hold_cnt}, {28'd0, h});
  endtask

  typedef struct { logic [3:0] r; int n; logic rs; } vec_t;
  vec_t tbl [12] = '{
    '{4'b0000, 2, 1'b0}, '{4'b0001, 1, 1'b0}, '{4'b0000, 2, 1'b0}, '{4'b1111, 9, 1'b0},
    '{4'b0101, 6, 1'b0}, '{4'b0110, 3, 1'b0}, '{4'b1001, 5, 1'b0}, '{4'b0000, 1, 1'b0},
    '{4'b1000, 2, 1'b0}, '{4'b1000, 1, 1'b1}, '{4'b1100, 7, 1'b0}, '{4'b0000, 2, 1'b0}
  };

  initial begin
    // Reset with all requests asserted.
    rst = 1'b1; req = 4'hF;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    lit("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    @(negedge clk); lit("first", 4'b0001, 1'b0, 1'b0, 1'b1, 4'd1);
    // Fair rotation a,b,c,d,a.
    repeat (4) @(negedge clk); lit("rot_b", 4'b0010, 1'b1, 1'b0, 1'b1, 4'd1);
    repeat (4) @(negedge clk); lit("rot_c", 4'b0100, 1'b0, 1'b1, 1'b1, 4'd1);
    repeat (4) @(negedge clk); lit("rot_d", 4'b1000, 1'b1, 1'b1, 1'b1, 4'd1);
    repeat (4) @(negedge clk); lit("rot_a", 4'b0001, 1'b0, 1'b0, 1'b1, 4'd1);
    req = 4'b0000;
    @(negedge clk); lit("idle1", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    // Single requester c held 10 cycles.
    req = 4'b0100;
    @(negedge clk); lit("single1", 4'b0100, 1'b0, 1'b1, 1'b1, 4'd1);
    repeat (4) @(negedge clk); lit("single5", 4'b0100, 1'b0, 1'b1, 1'b1, 4'd1);
    repeat (5) @(negedge clk); lit("single10", 4'b0100, 1'b0, 1'b1, 1'b1, 4'd2);
    req = 4'b0000;
    @(negedge clk); lit("idle_hold_xy", 4'b0000, 1'b0, 1'b1, 1'b0, 4'd0);
    // Wrap: pointer sits at d, a wins over b.
    req = 4'b0011;
    @(negedge clk); lit("wrap", 4'b0001, 1'b0, 1'b0, 1'b1, 4'd1);
    req = 4'b0000;
    @(negedge clk); lit("idle2", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    // Early release of b at hold_cnt=2 hands over to d.
    req = 4'b0010;
    repeat (2) @(negedge clk); lit("b_hold2", 4'b0010, 1'b1, 1'b0, 1'b1, 4'd2);
    req = 4'b1000;
    @(negedge clk); lit("early", 4'b1000, 1'b1, 1'b1, 1'b1, 4'd1);
    repeat (2) @(negedge clk); lit("d_hold3", 4'b1000, 1'b1, 1'b1, 1'b1, 4'd3);
    // Mid-burst reset, then pointer restarts at a.
    rst = 1'b1;
    @(negedge clk); lit("midrst", 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0; req = 4'b1010;
    @(negedge clk); lit("post_rst", 4'b0010, 1'b1, 1'b0, 1'b1, 4'd1);
    // Mixed directed vectors, checked by the model every cycle.
    foreach (tbl[i]) begin
      req = tbl[i].r; rst = tbl[i].rs;
      repeat (tbl[i].n) @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
